// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port 2 KiB data memory.
// Optional grant locking for atomic read-modify-write: define MEM_ARB_LOCK_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_TOP = 'h7FF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_TOP - 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    logic [0:0] state;
    logic [0:0] state_nxt;

    logic rr_ptr;
    logic acc_id;
    logic acc_we;
    logic acc_legal;

    logic req0_eff;
    logic req1_eff;
    logic any_req;
    logic sel_id;
    logic sel_legal;
    logic rr_nxt;
    acc_t sel;

`ifdef MEM_ARB_LOCK_EN
    // While locked, the lock owner keeps the pointer and the other side is masked.
    logic lock_act;
    logic lock_own;
    logic win_lock;

    assign win_lock = acc_id ? lock1 : lock0;
    assign req0_eff = req0 & ~(lock_act & lock_own);
    assign req1_eff = req1 & ~(lock_act & ~lock_own);
    assign rr_nxt   = win_lock ? acc_id : ~acc_id;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_act <= 1'b0;
            lock_own <= 1'b0;
        end else if (state == ACCESS) begin
            lock_act <= win_lock;
            lock_own <= acc_id;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = lock0 | lock1;
    assign req0_eff    = req0;
    assign req1_eff    = req1;
    assign rr_nxt      = ~acc_id;
`endif

    // Winner selection and address legality check for the IDLE cycle.
    always_comb begin
        any_req = req0_eff | req1_eff;
        sel_id  = (req0_eff & req1_eff) ? rr_ptr : req1_eff;
        if (sel_id) begin
            sel.we    = we1;
            sel.addr  = addr1;
            sel.wdata = wdata1;
        end else begin
            sel.we    = we0;
            sel.addr  = addr0;
            sel.wdata = wdata0;
        end
        sel_legal = ~sel.addr[0] && (sel.addr <= LAST_WORD);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access launch on IDLE->ACCESS, read completion and pointer update on ACCESS->IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            acc_id      <= 1'b0;
            acc_we      <= 1'b0;
            acc_legal   <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_wr_en   <= 1'b0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_wr_en <= 1'b0;
            if (state == IDLE && any_req) begin
                acc_id      <= sel_id;
                acc_we      <= sel.we;
                acc_legal   <= sel_legal;
                mem_address <= sel.addr;
                mem_data_in <= sel.wdata;
                mem_wr_en   <= sel.we & sel_legal;
                gnt0        <= ~sel_id;
                gnt1        <= sel_id;
                err0        <= ~sel_id & ~sel_legal;
                err1        <= sel_id & ~sel_legal;
            end
            if (state == ACCESS) begin
                rr_ptr <= rr_nxt;
                if (~acc_we & acc_legal) begin
                    if (acc_id) begin
                        rdata1  <= mem_data_out;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= mem_data_out;
                        rvalid0 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a big-endian byte memory model.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_wr_en;

    int tests_run;
    int tests_failed;

    logic [7:0] mem [0:65535];

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_data_out = {mem[mem_address], mem[16'(mem_address + 16'd1)]};

    always @(posedge clock) begin
        if (mem_wr_en) begin
            mem[mem_address]                <= mem_data_in[15:8];
            mem[16'(mem_address + 16'd1)]   <= mem_data_in[7:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive0(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic l);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic l);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_wr_en} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 0000000",
                     {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_wr_en});
        end
        tests_run++;
        if (rdata0 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_rdata0 got %h want 0000", rdata0);
        end
        tests_run++;
        if (rdata1 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_rdata1 got %h want 0000", rdata1);
        end
        tests_run++;
        if (mem_address !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mem_address got %h want 0000", mem_address);
        end
        tests_run++;
        if (mem_data_in !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mem_data_in got %h want 0000", mem_data_in);
        end
    endtask

    task automatic test_alternate();
        logic [3:0] tab [0:7];
        tab = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
        drive0(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0);
        drive1(1'b1, 1'b0, 16'h00C8, 16'h0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            tests_run++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== tab[k]) begin
                tests_failed++;
                $display("FAIL alternate_cycle%0d gnt0,gnt1,rvalid0,rvalid1 got %b want %b",
                         k, {gnt0, gnt1, rvalid0, rvalid1}, tab[k]);
            end
            if (k == 6) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tests_run++;
        if (rdata0 !== 16'h4848) begin
            tests_failed++;
            $display("FAIL alternate_rdata0 got %h want 4848", rdata0);
        end
        tests_run++;
        if (rdata1 !== 16'hC8C8) begin
            tests_failed++;
            $display("FAIL alternate_rdata1 got %h want c8c8", rdata1);
        end
    endtask

    task automatic test_single_read();
        drive0(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt0, gnt1, rvalid0, mem_address} !== {3'b100, 16'h0008}) begin
            tests_failed++;
            $display("FAIL read_grant gnt0,gnt1,rvalid0,addr got %b %h want 100 0008",
                     {gnt0, gnt1, rvalid0}, mem_address);
        end
        req0 = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL read_rvalid gnt0,gnt1,rvalid0,rvalid1 got %b want 0010",
                     {gnt0, gnt1, rvalid0, rvalid1});
        end
        tests_run++;
        if (rdata0 !== 16'h0010) begin
            tests_failed++;
            $display("FAIL read_rdata0 got %h want 0010", rdata0);
        end
        @(negedge clock);
        tests_run++;
        if ({gnt0, rvalid0} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_quiet gnt0,rvalid0 got %b want 00", {gnt0, rvalid0});
        end
    endtask

    task automatic test_write_read();
        drive1(1'b1, 1'b1, 16'h07FE, 16'h1234, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt1, mem_wr_en, mem_address, mem_data_in} !== {2'b11, 16'h07FE, 16'h1234}) begin
            tests_failed++;
            $display("FAIL write_launch gnt1,wr_en,addr,data got %b %h %h want 11 07fe 1234",
                     {gnt1, mem_wr_en}, mem_address, mem_data_in);
        end
        req1 = 1'b0;
        we1  = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid1, mem_wr_en} !== 2'b00) begin
            tests_failed++;
            $display("FAIL write_no_rvalid rvalid1,wr_en got %b want 00", {rvalid1, mem_wr_en});
        end
        drive0(1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0);
        @(negedge clock);
        req0 = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid0, rdata0} !== {1'b1, 16'h1234}) begin
            tests_failed++;
            $display("FAIL read_after_write rvalid0,rdata0 got %b %h want 1 1234", rvalid0, rdata0);
        end
        drive0(1'b1, 1'b0, 16'h068C, 16'h0000, 1'b0);
        @(negedge clock);
        req0 = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid0, rdata0} !== {1'b1, 16'h0003}) begin
            tests_failed++;
            $display("FAIL read_068c rvalid0,rdata0 got %b %h want 1 0003", rvalid0, rdata0);
        end
    endtask

    task automatic test_errors();
        drive0(1'b1, 1'b0, 16'h0009, 16'h0000, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt0, err0, mem_wr_en} !== 3'b110) begin
            tests_failed++;
            $display("FAIL err_odd gnt0,err0,wr_en got %b want 110", {gnt0, err0, mem_wr_en});
        end
        req0 = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid0, err0, rdata0} !== {2'b00, 16'h0003}) begin
            tests_failed++;
            $display("FAIL err_odd_after rvalid0,err0,rdata0 got %b %h want 00 0003",
                     {rvalid0, err0}, rdata0);
        end
        drive0(1'b1, 1'b1, 16'h07FF, 16'hBEEF, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt0, err0, mem_wr_en} !== 3'b110) begin
            tests_failed++;
            $display("FAIL err_top gnt0,err0,wr_en got %b want 110", {gnt0, err0, mem_wr_en});
        end
        req0 = 1'b0;
        we0  = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid0, rdata0} !== {1'b0, 16'h0003}) begin
            tests_failed++;
            $display("FAIL err_top_after rvalid0,rdata0 got %b %h want 0 0003", rvalid0, rdata0);
        end
        tests_run++;
        if ({mem[16'h07FE], mem[16'h07FF], mem[16'h0000]} !== 24'h123400) begin
            tests_failed++;
            $display("FAIL err_top_mem bytes 7fe,7ff,000 got %h want 123400",
                     {mem[16'h07FE], mem[16'h07FF], mem[16'h0000]});
        end
    endtask

    task automatic test_reset_mid_access();
        drive0(1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt0, mem_wr_en} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midrst_launch gnt0,wr_en got %b want 11", {gnt0, mem_wr_en});
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_wr_en, gnt0, gnt1, err0, rvalid0} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midrst_drop wr_en,gnt0,gnt1,err0,rvalid0 got %b want 00000",
                     {mem_wr_en, gnt0, gnt1, err0, rvalid0});
        end
        tests_run++;
        if ({rdata0, rdata1, mem_address, mem_data_in} !== 64'h0) begin
            tests_failed++;
            $display("FAIL midrst_zero rdata0,rdata1,addr,data got %h %h %h %h want 0",
                     rdata0, rdata1, mem_address, mem_data_in);
        end
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if ({mem[16'h0100], mem[16'h0101]} !== 16'h5555) begin
            tests_failed++;
            $display("FAIL midrst_mem word 0100 got %h want 5555", {mem[16'h0100], mem[16'h0101]});
        end
        drive0(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0);
        drive1(1'b1, 1'b0, 16'h00C8, 16'h0000, 1'b0);
        @(negedge clock);
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midrst_next_grant gnt0,gnt1 got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({rvalid0, rdata0} !== {1'b1, 16'h4848}) begin
            tests_failed++;
            $display("FAIL midrst_read rvalid0,rdata0 got %b %h want 1 4848", rvalid0, rdata0);
        end
        @(negedge clock);
    endtask

    task automatic test_lock();
        logic wins [0:4];
        logic exp_win [0:4];
        int n;
        int g0;
`ifdef MEM_ARB_LOCK_EN
        exp_win = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_win = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        wins = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n  = 0;
        g0 = 0;
        do_reset();
        drive0(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b1);
        drive1(1'b1, 1'b0, 16'h00C8, 16'h0000, 1'b0);
        for (int c = 0; c < 24 && n < 5; c++) begin
            @(negedge clock);
            if (gnt0 | gnt1) begin
                wins[n] = gnt1;
                if (gnt0) g0++;
                n++;
                if (n == 5) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                    lock0 = 1'b0;
                end
            end else begin
                lock0 = (g0 < 3);
            end
        end
        tests_run++;
        if (n !== 5) begin
            tests_failed++;
            $display("FAIL lock_grant_count got %0d want 5", n);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < n) begin
                tests_run++;
                if (wins[i] !== exp_win[i]) begin
                    tests_failed++;
                    $display("FAIL lock_grant%0d winner got %0d want %0d", i, wins[i], exp_win[i]);
                end
            end
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        drive0(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0008] = 8'h00; mem[16'h0009] = 8'h10;
        mem[16'h0048] = 8'h48; mem[16'h0049] = 8'h48;
        mem[16'h00C8] = 8'hC8; mem[16'h00C9] = 8'hC8;
        mem[16'h068C] = 8'h00; mem[16'h068D] = 8'h03;
        mem[16'h0100] = 8'h55; mem[16'h0101] = 8'h55;

        test_reset();
        test_alternate();
        test_single_read();
        test_write_read();
        test_errors();
        test_reset_mid_access();
        test_lock();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
